fetch_stage: RTL and testbench

Instruction-fetch stage that drives the PC-select path. It holds the architectural PC and issues one instruction-memory request at a time. It registers each returned instruction into the IF/ID pipeline register. It accepts a redirect (taken branch/jump; the next-PC mux select and its output) and a stall from the hazard unit.

---
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. It holds the architectural PC and keeps at most one
//   instruction-memory request outstanding. Each returned instruction is
//   registered into the IF/ID pipeline register. If an instruction returns while
//   the hazard unit is stalling, a one-entry skid buffer holds it. A redirect
//   (taken branch/jump) overrides stall, squashes IF/ID and discards the skid
//   buffer. Any request already in flight is then drained in DROP.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   redirect      taken branch/jump this cycle
//   redirect_pc   redirect target; bits [1:0] are ignored
//   stall         hold IF/ID, do not advance
//   imem_req      registered request strobe, one cycle per fetch
//   imem_addr     registered fetch address, valid while imem_req=1
//   imem_rvalid   instruction return strobe
//   imem_rdata    returned instruction
//   if_id_valid   IF/ID holds a live instruction
//   if_id_pc      PC of the IF/ID instruction
//   if_id_pc4     if_id_pc + 4
//   if_id_instr   IF/ID instruction
//
// state | meaning
// ------+--------------------------------------------------------------------
// ISSUE | request strobe on the bus (straight out of reset: strobe being raised)
// WAIT  | request in flight, waiting for imem_rvalid
// HOLD  | returned instruction parked in the skid buffer until stall drops
// DROP  | a discarded request is in flight; its response is swallowed

module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  state_t          state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [31:0]     skid, skid_d;
  logic            deliver;
  logic [31:0]     deliver_instr;

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    skid_d        = skid;
    deliver       = 1'b0;
    deliver_instr = skid;

    unique case (state)
      // Out of reset the strobe register is still low, so ISSUE is held one
      // extra cycle to raise it. After that, ISSUE always coincides with the strobe.
      ISSUE: state_d = imem_req ? WAIT : ISSUE;
      WAIT: begin
        if (imem_rvalid) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            state_d       = ISSUE;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = skid;
          state_d       = ISSUE;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase

    if (deliver) pc_d = pc + PC_STEP;

    // Redirect wins over everything, stall included. Leave through DROP only
    // when a response is still owed by the memory.
    if (redirect) begin
      deliver = 1'b0;
      skid_d  = '0;
      pc_d    = redirect_pc & ALIGN_MASK;
      case (state)
        ISSUE:   state_d = imem_req ? DROP : ISSUE;
        WAIT:    state_d = imem_rvalid ? ISSUE : DROP;
        HOLD:    state_d = ISSUE;
        DROP:    state_d = imem_rvalid ? ISSUE : DROP;
        default: state_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      skid        <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_instr <= '0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      skid     <= skid_d;
      imem_req <= (state_d == ISSUE);
      if (state_d == ISSUE) imem_addr <= pc_d;

      if (redirect) begin
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if (deliver) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= pc;
          if_id_pc4   <= pc + PC_STEP;
          if_id_instr <= deliver_instr;
        end else begin
          if_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. A bench-owned memory answers each request after a
// programmable latency with an instruction word derived from its address.
// A transaction-level model runs alongside. It predicts the fetch address
// stream and the program-order delivery stream, tracking redirects. It also
// tracks what IF/ID should contain, and checks the DUT against this every cycle.
// Directed steps pin exact cycle-level values computed by hand.

module tb_fetch_stage;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Memory: one response per request, mem_lat cycles after the strobe.
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
      mem_cnt     <= 0;
      mem_addr_q  <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (mem_cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= instr_of(mem_addr_q);
      end
      if (mem_cnt != 0) mem_cnt <= mem_cnt - 1;
      if (imem_req) begin
        if (mem_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= instr_of(imem_addr);
        end else begin
          mem_addr_q <= imem_addr;
          mem_cnt    <= mem_lat - 1;
        end
      end
    end
  end

  // Transaction-level model and per-cycle compare.
  logic [31:0] exp_fetch, exp_deliver;
  logic        outstanding;
  logic        p_stall, p_redir;
  logic        m_valid;
  logic [31:0] m_pc, m_pc4, m_instr;
  int          n_deliv = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_if_id_valid", if_id_valid, 0);
      exp_fetch   = RESET_PC;
      exp_deliver = RESET_PC;
      outstanding = 1'b0;
      p_stall     = 1'b0;
      p_redir     = 1'b0;
      m_valid     = 1'b0;
      m_pc        = '0;
      m_pc4       = '0;
      m_instr     = '0;
    end else begin
      if (p_redir) begin
        chk("redirect_bubble", if_id_valid, 0);
        m_valid = 1'b0;
      end else if (p_stall) begin
        chk("stall_hold_valid", if_id_valid, m_valid);
        chk("stall_hold_pc", if_id_pc, m_pc);
        chk("stall_hold_pc4", if_id_pc4, m_pc4);
        chk("stall_hold_instr", if_id_instr, m_instr);
      end else if (if_id_valid) begin
        chk("deliver_pc", if_id_pc, exp_deliver);
        chk("deliver_pc4", if_id_pc4, exp_deliver + 32'd4);
        chk("deliver_instr", if_id_instr, instr_of(exp_deliver));
        m_valid     = 1'b1;
        m_pc        = exp_deliver;
        m_pc4       = exp_deliver + 32'd4;
        m_instr     = instr_of(exp_deliver);
        exp_deliver = exp_deliver + 32'd4;
        n_deliv++;
      end else begin
        m_valid = 1'b0;
      end

      if (imem_req) begin
        chk("single_outstanding", outstanding, 0);
        chk("fetch_addr", imem_addr, exp_fetch);
        exp_fetch   = exp_fetch + 32'd4;
        outstanding = 1'b1;
      end
      if (imem_rvalid) outstanding = 1'b0;

      if (redirect) begin
        exp_fetch   = redirect_pc & 32'hFFFF_FFFC;
        exp_deliver = exp_fetch;
      end
      p_redir = redirect;
      p_stall = stall;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = imem_req;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          seen;
    int          d0;
    logic [39:0] spat;

    rst = 1'b1; redirect = 1'b0; stall = 1'b0; redirect_pc = '0; mem_lat = 1;
    tick(); tick();
    rst = 1'b0;

    // Straight-line fetch, 1-cycle memory.
    tick();
    chk("c1_req", imem_req, 1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", if_id_valid, 0);
    tick();
    chk("c2_req", imem_req, 0);
    chk("c2_valid", if_id_valid, 0);
    tick();
    chk("c3_valid", if_id_valid, 1);
    chk("c3_pc", if_id_pc, 32'h0);
    chk("c3_pc4", if_id_pc4, 32'h4);
    chk("c3_instr", if_id_instr, 32'h1357_6420);
    chk("c3_addr", imem_addr, 32'h4);
    tick();
    chk("c4_valid", if_id_valid, 0);
    tick();
    chk("c5_valid", if_id_valid, 1);
    chk("c5_pc", if_id_pc, 32'h4);
    chk("c5_instr", if_id_instr, 32'h1353_6424);
    chk("c5_addr", imem_addr, 32'h8);

    // Stall for three cycles while the 0x8 response returns.
    stall = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_valid", if_id_valid, 1);
      chk("stall_pc", if_id_pc, 32'h4);
      chk("stall_noreq", imem_req, 0);
    end
    stall = 1'b0;
    tick();
    chk("skid_valid", if_id_valid, 1);
    chk("skid_pc", if_id_pc, 32'h8);
    chk("skid_instr", if_id_instr, 32'h135F_6428);
    chk("skid_next_addr", imem_addr, 32'hC);

    // Redirect in the cycle the 0x10 request is on the bus.
    tick(); tick();
    chk("c11_req", imem_req, 1);
    chk("c11_addr", imem_addr, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("redir_valid", if_id_valid, 0);
    chk("redir_noreq", imem_req, 0);
    tick();
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_req", imem_req, 1);
    chk("redir_valid2", if_id_valid, 0);
    tick();
    chk("redir_valid3", if_id_valid, 0);
    tick();
    chk("t100_valid", if_id_valid, 1);
    chk("t100_pc", if_id_pc, 32'h100);
    chk("t100_instr", if_id_instr, 32'h1257_6520);

    // Redirect together with stall while an instruction sits in the skid buffer.
    tick();
    stall = 1'b1;
    tick();
    chk("hold_pc", if_id_pc, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("rs_valid", if_id_valid, 0);
    chk("rs_req", imem_req, 1);
    chk("rs_addr", imem_addr, 32'h200);
    tick(); tick();
    chk("t200_valid", if_id_valid, 1);
    chk("t200_pc", if_id_pc, 32'h200);
    chk("t200_instr", if_id_instr, 32'h1157_6620);

    // PC wrap.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    chk("wrap_valid", if_id_valid, 1);
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'hECAB_9BDC);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Reset while in WAIT with a live IF/ID entry held by stall.
    stall = 1'b1;
    tick();
    chk("prerst_valid", if_id_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_valid", if_id_valid, 0);
    chk("async_req", imem_req, 0);
    chk("async_pc", if_id_pc, 32'h0);
    chk("async_instr", if_id_instr, 32'h0);
    stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    wait_req(8, seen);
    chk("postrst_req_seen", seen, 1);
    chk("postrst_addr", imem_addr, RESET_PC);

    // Longer memory latency with an irregular stall pattern and one redirect.
    mem_lat = 2;
    d0   = n_deliv;
    spat = 40'hC3_5A_0F_96_31;
    for (int i = 0; i < 40; i++) begin
      stall       = spat[i];
      redirect    = (i == 20);
      redirect_pc = 32'h43;
      tick();
    end
    redirect = 1'b0; stall = 1'b0; mem_lat = 1;
    repeat (10) tick();
    chk("progress", n_deliv > d0 + 4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
